// File: rtl/masked_tp_pkg.sv
// Shared types and share-wise linear helpers for the masked transition pipeline.
package masked_tp_pkg;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Helpers take the real width and rotate amount as arguments so one package serves every instance.
    function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x, input int w, input int r);
        logic [MAX_W-1:0] m;
        logic [MAX_W-1:0] xm;
        m  = '1;
        m  = m >> (MAX_W - w);
        xm = x & m;
        return ((xm << r) | (xm >> (w - r))) & m;
    endfunction

    function automatic logic [MAX_W-1:0] mix(input logic [MAX_W-1:0] x, input int w, input int r);
        return x ^ rotl(x, w, r);
    endfunction

endpackage

// File: rtl/masked_transition_pipeline_if.sv
// Bundle of key, plaintext, randomness and ciphertext signals for the masked pipeline.
interface masked_transition_pipeline_if #(
    parameter int WIDTH = 8
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and the payload is held stable while valid waits for ready.
    logic             key_load;
    logic [WIDTH-1:0] key_s0;
    logic [WIDTH-1:0] key_s1;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] pt_s0;
    logic [WIDTH-1:0] pt_s1;
    logic [WIDTH-1:0] rnd;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ct_s0;
    logic [WIDTH-1:0] ct_s1;
    logic             busy;

    modport master (
        output key_load, key_s0, key_s1, in_valid, pt_s0, pt_s1, rnd, out_ready,
        input  in_ready, out_valid, ct_s0, ct_s1, busy
    );

    modport slave (
        input  key_load, key_s0, key_s1, in_valid, pt_s0, pt_s1, rnd, out_ready,
        output in_ready, out_valid, ct_s0, ct_s1, busy
    );

endinterface

// File: rtl/masked_share_round.sv
// One share of a masked round: mix(s) ^ k ^ r, kept in its own hierarchy per share.
module masked_share_round
    import masked_tp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ROT   = 1
) (
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] y
);

    assign y = WIDTH'(mix(MAX_W'(s), WIDTH, ROT)) ^ k ^ r;

endmodule

// File: rtl/masked_transition_pipeline.sv
// Two-share key-XOR/rotate-mix pipeline with mask refresh on every state write and
// optional ping-pong precharged banks so each register write starts from zero.
module masked_transition_pipeline
    import masked_tp_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int ROUNDS    = 4,
    parameter int ROT       = 1,
    parameter int PRECHARGE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    masked_transition_pipeline_if.slave  bus,
    output state_t                       state_dbg
);

    localparam int            CW   = $clog2(ROUNDS + 1);
    localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a0, a1, b0, b1;
    logic [WIDTH-1:0] k0, k1;
    logic [WIDTH-1:0] ct0, ct1;
    logic             out_valid_q;
    logic             rd_b;
    logic [WIDTH-1:0] src0, src1;
    logic [WIDTH-1:0] nxt0, nxt1;

    // Odd rounds read bank B when precharging; the single-bank build always reads A.
    assign rd_b = (PRECHARGE != 0) && cnt[0];
    assign src0 = rd_b ? b0 : a0;
    assign src1 = rd_b ? b1 : a1;

    masked_share_round #(.WIDTH(WIDTH), .ROT(ROT)) u_round_s0 (
        .s (src0),
        .k (k0),
        .r (bus.rnd),
        .y (nxt0)
    );

    masked_share_round #(.WIDTH(WIDTH), .ROT(ROT)) u_round_s1 (
        .s (src1),
        .k (k1),
        .r (bus.rnd),
        .y (nxt1)
    );

    assign bus.in_ready  = (state == IDLE);
    assign bus.busy      = (state == RUN);
    assign bus.out_valid = out_valid_q;
    assign bus.ct_s0     = ct0;
    assign bus.ct_s1     = ct1;
    assign state_dbg     = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            a0          <= '0;
            a1          <= '0;
            b0          <= '0;
            b1          <= '0;
            k0          <= '0;
            k1          <= '0;
            ct0         <= '0;
            ct1         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // The key is frozen for the whole of RUN.
            if (bus.key_load && (state != RUN)) begin
                k0 <= bus.key_s0;
                k1 <= bus.key_s1;
            end
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a0    <= bus.pt_s0 ^ k0 ^ bus.rnd;
                        a1    <= bus.pt_s1 ^ k1 ^ bus.rnd;
                        cnt   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (cnt == LAST) begin
                        ct0         <= nxt0;
                        ct1         <= nxt1;
                        a0          <= '0;
                        a1          <= '0;
                        b0          <= '0;
                        b1          <= '0;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (PRECHARGE != 0) begin
                            if (rd_b) begin
                                a0 <= nxt0;
                                a1 <= nxt1;
                                b0 <= '0;
                                b1 <= '0;
                            end else begin
                                b0 <= nxt0;
                                b1 <= nxt1;
                                a0 <= '0;
                                a1 <= '0;
                            end
                        end else begin
                            a0 <= nxt0;
                            a1 <= nxt1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state       <= IDLE;
                        if (PRECHARGE != 0) begin
                            ct0 <= '0;
                            ct1 <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_masked_transition_pipeline.sv
// Bench for masked_transition_pipeline: a ROUNDS=1 single-bank instance and a ROUNDS=4 precharged instance.
module tb_masked_transition_pipeline;
    import masked_tp_pkg::*;

    localparam int W   = 8;
    localparam int ROT = 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    masked_transition_pipeline_if #(.WIDTH(W)) bus1 ();
    masked_transition_pipeline_if #(.WIDTH(W)) bus4 ();
    state_t st1;
    state_t st4;

    masked_transition_pipeline #(.WIDTH(W), .ROUNDS(1), .ROT(ROT), .PRECHARGE(0)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus1),
        .state_dbg (st1)
    );

    masked_transition_pipeline #(.WIDTH(W), .ROUNDS(4), .ROT(ROT), .PRECHARGE(1)) u_dut4 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus4),
        .state_dbg (st4)
    );

    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0]  cur_key;
    logic [7:0]  r1_s0 [3];
    logic [7:0]  r1_s1 [3];
    logic [7:0]  rnd_vec [3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Unmasked reference: the value the two ciphertext shares must XOR to.
    function automatic logic [7:0] ref_ct(input logic [7:0] pt, input logic [7:0] key, input int rounds);
        int x;
        int rot;
        int k;
        x = int'(pt ^ key);
        k = int'(key);
        for (int i = 0; i < rounds; i++) begin
            rot = ((x * (2 ** ROT)) % 256) + (x / (2 ** (W - ROT)));
            x   = x ^ rot ^ k;
        end
        return 8'(x);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_keys(input logic [7:0] k0, input logic [7:0] k1);
        bus1.key_s0 = k0; bus1.key_s1 = k1; bus1.key_load = 1'b1;
        bus4.key_s0 = k0; bus4.key_s1 = k1; bus4.key_load = 1'b1;
        tick;
        bus1.key_load = 1'b0;
        bus4.key_load = 1'b0;
        cur_key = k0 ^ k1;
    endtask

    task automatic run1(input logic [7:0] r, output logic [7:0] c0, output logic [7:0] c1);
        bus1.pt_s0 = 8'h0F; bus1.pt_s1 = 8'h55; bus1.rnd = r; bus1.in_valid = 1'b1;
        tick;
        bus1.in_valid = 1'b0;
        check("r1_busy", bus1.busy, 1);
        check("r1_not_valid_yet", bus1.out_valid, 0);
        tick;
        check("r1_valid", bus1.out_valid, 1);
        c0 = bus1.ct_s0;
        c1 = bus1.ct_s1;
        check("r1_vec_96", c0 ^ c1, 8'h96);
        bus1.out_ready = 1'b1;
        tick;
        bus1.out_ready = 1'b0;
        check("r1_done", bus1.out_valid, 0);
    endtask

    task automatic op4(input logic [7:0] p0, input logic [7:0] p1, input int hold, input bit kl_run);
        int lat;
        logic [7:0] h0, h1;
        exp_q.push_back(ref_ct(p0 ^ p1, cur_key, 4));
        check("op_in_ready", bus4.in_ready, 1);
        bus4.pt_s0 = p0; bus4.pt_s1 = p1; bus4.in_valid = 1'b1; bus4.rnd = 8'($urandom);
        tick;
        bus4.in_valid = 1'b0;
        lat = 0;
        while (!bus4.out_valid && lat < 20) begin
            check("bank_zero", 32'(((u_dut4.a0 | u_dut4.a1) == 8'h00) || ((u_dut4.b0 | u_dut4.b1) == 8'h00)), 1);
            if (kl_run && lat == 1) begin
                bus4.key_s0 = 8'hFF; bus4.key_s1 = 8'h00; bus4.key_load = 1'b1;
            end
            bus4.rnd = 8'($urandom_range(0, 255));
            tick;
            bus4.key_load = 1'b0;
            lat++;
        end
        check("latency", lat, 4);
        h0 = bus4.ct_s0;
        h1 = bus4.ct_s1;
        for (int i = 0; i < hold; i++) begin
            bus4.in_valid = (i == 2);
            bus4.rnd = 8'($urandom);
            tick;
            check("hold_valid", bus4.out_valid, 1);
            check("hold_ct", {bus4.ct_s0, bus4.ct_s1}, {h0, h1});
            check("hold_in_ready", bus4.in_ready, 0);
        end
        bus4.in_valid = 1'b0;
        check("ct_xor", h0 ^ h1, exp_q.pop_front());
        bus4.out_ready = 1'b1;
        tick;
        bus4.out_ready = 1'b0;
        check("valid_drop", bus4.out_valid, 0);
        check("ct_cleared", {bus4.ct_s0, bus4.ct_s1}, 0);
        check("back_idle", bus4.in_ready, 1);
        check("not_busy", bus4.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus1.key_load = 0; bus1.key_s0 = 0; bus1.key_s1 = 0; bus1.in_valid = 0;
        bus1.pt_s0 = 0; bus1.pt_s1 = 0; bus1.rnd = 0; bus1.out_ready = 0;
        bus4.key_load = 0; bus4.key_s0 = 0; bus4.key_s1 = 0; bus4.in_valid = 0;
        bus4.pt_s0 = 0; bus4.pt_s1 = 0; bus4.rnd = 0; bus4.out_ready = 0;
        cur_key = 8'h00;
        tick;
        tick;
        check("rst_in_ready", bus4.in_ready, 1);
        check("rst_out_valid", bus4.out_valid, 0);
        check("rst_busy", bus4.busy, 0);
        check("rst_ct", {bus4.ct_s0, bus4.ct_s1}, 0);
        check("rst_state", 32'(st4), 32'(IDLE));
        check("rst_state1", 32'(st1), 32'(IDLE));
        rst = 1'b0;
        tick;

        load_keys(8'hA5, 8'h99);
        check("key_3c", cur_key, 8'h3C);

        // Same vector under three masks: shares move, the unmasked value does not.
        rnd_vec[0] = 8'h00; rnd_vec[1] = 8'h17; rnd_vec[2] = 8'hE2;
        for (int i = 0; i < 3; i++) begin
            run1(rnd_vec[i], r1_s0[i], r1_s1[i]);
            tick;
        end
        check("mask17_differs", 32'(r1_s0[1] != r1_s0[0]), 1);
        check("maskE2_differs", 32'(r1_s0[2] != r1_s0[0]), 1);

        op4(8'h0F, 8'h55, 0, 1'b0);
        op4(8'h0F, 8'h55, 10, 1'b1);
        load_keys(8'hFF, 8'h00);
        op4(8'h0F, 8'h55, 2, 1'b0);

        for (int n = 0; n < 20; n++) begin
            if ($urandom_range(0, 3) == 0)
                load_keys(8'($urandom), 8'($urandom));
            op4(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset in the middle of an operation discards it.
        bus4.pt_s0 = 8'($urandom); bus4.pt_s1 = 8'($urandom); bus4.in_valid = 1'b1;
        tick;
        bus4.in_valid = 1'b0;
        tick;
        tick;
        check("cnt_at_2", 32'(u_dut4.cnt), 2);
        rst = 1'b1;
        #1;
        check("arst_out_valid", bus4.out_valid, 0);
        check("arst_busy", bus4.busy, 0);
        check("arst_ct", {bus4.ct_s0, bus4.ct_s1}, 0);
        check("arst_in_ready", bus4.in_ready, 1);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick;
            check("no_out_after_rst", bus4.out_valid, 0);
        end
        check("in_ready_after_rst", bus4.in_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/masked_transition_pipeline.md
# masked_transition_pipeline

Parametrised successor to the unprotected key-XOR/mix transition block. It processes data as two Boolean shares with fresh randomness injected on every state write. It runs a configurable number of key-XOR/rotate-mix rounds under a valid/ready handshake. An optional ping-pong precharge bank makes every state-register write a 0→value transition, so Hamming distance reduces to Hamming weight of a masked share. It sits in the masking-countermeasure test suite as the protected counterpart for VERICA/FORTIFY leakage comparison.

## Interface
- WIDTH, 8, datapath/share width (≥2)
- ROUNDS, 4, mix rounds per operation (≥1)
- ROT, 1, left-rotate amount in mix (1..WIDTH-1)
- PRECHARGE, 1, 1 = ping-pong precharged state banks and zeroed outputs, 0 = single bank
- clk  in  1  sole clock, rising edge
- rst  in  1  one clock; reset is asynchronous and active-high
- key_load  in  1  capture key shares
- key_s0, key_s1  in  WIDTH  key shares (key = key_s0^key_s1)
- in_valid  in  1  plaintext shares valid
- in_ready  out  1  block can accept
- pt_s0, pt_s1  in  WIDTH  plaintext shares
- rnd  in  WIDTH  fresh randomness, sampled on every consuming edge
- out_valid  out  1  ciphertext shares valid
- out_ready  in  1  consumer accepts
- ct_s0, ct_s1  out  WIDTH  ciphertext shares
- busy  out  1  high in RUN

## Operation
- Mix: mix(x) = x ^ rotl(x, ROT). It is linear, so it is applied share-wise. Shares are never recombined inside the block.
- Key regs k0/k1 load on key_load in IDLE or DONE. key_load in RUN is ignored, and the key in use stays stable for the whole operation.
- FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: A_i <= pt_si ^ k_i ^ rnd; cnt <= 0; go to RUN.
- RUN: each edge performs one round, S_i' = mix(S_i) ^ k_i ^ rnd. The same rnd word is applied to both shares, which refreshes the mask.
  - PRECHARGE=1: round cnt reads bank A if cnt even, otherwise bank B. It writes the other bank and clears the read bank to 0 on the same edge.
  - PRECHARGE=0: only bank A is used; A <= round(A).
  - Final round (cnt==ROUNDS-1): the result goes to ct_s0/ct_s1, not to a bank. All banks clear to 0, out_valid<=1, go to DONE.
  - Otherwise cnt++.
- DONE:
  - out_valid=1, ct held stable while out_ready=0.
  - On out_ready: out_valid<=0, go to IDLE. If PRECHARGE=1, ct_s0/ct_s1 also <= 0.
  - in_ready=0 in DONE. There is no same-cycle overlap.
- Unmasked result ct_s0^ct_s1 depends only on pt, key, ROUNDS and ROT, never on rnd.
- Consumption of rnd: ROUNDS+1 words per operation. One is taken at the accept edge and one at each round edge.

## Timing
- Reset (async, any state): FSM=IDLE; A, B, k0, k1, cnt, ct_s0, ct_s1 = 0; out_valid=0, busy=0. in_ready=1 (decoded from IDLE).
- Reset mid-RUN or mid-DONE: the operation is discarded and no out_valid is produced.
- Latency: accept at edge t, out_valid high after edge t+ROUNDS. Throughput is one operation per ROUNDS+2 cycles when out_ready is held high.
- in_ready and busy are combinational decodes of FSM state only.
- PRECHARGE=1 invariant: every bank register and ct register goes through 0 between any two non-zero values.
- cnt width: $clog2(ROUNDS+1).

## Structure
- Package masked_tp_pkg holds:
  - the state enum {IDLE, RUN, DONE};
  - the rotl and mix functions, parametrised by WIDTH and ROT.
- Sub-module masked_share_round is combinational and computes mix(s) ^ k ^ r. It is instantiated once per share, so the shares stay in separate hierarchy for leakage tools.

## Test plan
- Functional vector, WIDTH=8, ROUNDS=1, ROT=1, rnd=0:
  - key_s0=A5, key_s1=99 (key 3C); pt_s0=0F, pt_s1=55 (pt 5A).
  - Expect ct_s0^ct_s1=96 one cycle after accept.
- Mask independence: repeat the same vector with rnd=17, then E2.
  - Shares must differ from run 1; the XOR must still be 96.
- Latency and precharge, ROUNDS=4, PRECHARGE=1:
  - out_valid rises exactly 4 edges after accept.
  - In each RUN cycle one bank is 00.
  - ct returns to 00 after the out handshake.
- Backpressure: hold out_ready=0 for 10 cycles.
  - out_valid and ct stay stable, in_ready=0, and a pulse on in_valid is not accepted.
- key_load during RUN with new key FF/00 is ignored; the result equals the old-key result. The same key_load in IDLE takes effect for the next operation.
- Assert rst in the cycle with cnt=2: all outputs are 0 asynchronously, no out_valid, and in_ready=1 after release.
